// File: rtl/trace_capture_if.sv
// Probe, trigger-control and readback signals of the trace_capture buffer.
// The master modport drives captures; the slave modport is the buffer itself.
interface trace_capture_if #(
    parameter int unsigned CH_W = 16,
    parameter int unsigned NCH  = 4,
    parameter int unsigned AW   = 5,
    parameter int unsigned TS_W = 16
);
    logic                  arm_i;
    logic [1:0]            mode_i;
    logic                  trig_i;
    logic [CH_W-1:0]       match_i;
    logic [TS_W-1:0]       limit_i;
    logic [AW-1:0]         post_i;
    logic                  sample_v_i;
    logic [NCH*CH_W-1:0]   sample_i;
    logic [AW-1:0]         rd_addr_i;
    logic [NCH*CH_W-1:0]   rd_data_o;
    logic [TS_W-1:0]       rd_ts_o;
    logic [1:0]            state_o;
    logic [AW:0]           count_o;
    logic [AW-1:0]         trig_pos_o;

    modport master (
        output arm_i, mode_i, trig_i, match_i, limit_i, post_i, sample_v_i, sample_i, rd_addr_i,
        input  rd_data_o, rd_ts_o, state_o, count_o, trig_pos_o
    );

    modport slave (
        input  arm_i, mode_i, trig_i, match_i, limit_i, post_i, sample_v_i, sample_i, rd_addr_i,
        output rd_data_o, rd_ts_o, state_o, count_o, trig_pos_o
    );
endinterface

// File: rtl/trace_capture.sv
// Circular pipeline trace buffer: samples probes with a cycle stamp until a trigger
// plus post-trigger window, then freezes and serves the window through a registered read port.
module trace_capture #(
    parameter int unsigned CH_W  = 16,
    parameter int unsigned NCH   = 4,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned TS_W  = 16
) (
    input logic            clk,
    input logic            rst,
    trace_capture_if.slave bus
);
    localparam int unsigned DW = NCH * CH_W;
    localparam logic [AW:0] FillMax = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPre  = 2'b01,
        StPost = 2'b10,
        StDone = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic [TS_W-1:0] stamp_q, stamp_d;
    logic [1:0]      mode_q, mode_d;
    logic [CH_W-1:0] match_q, match_d;
    logic [TS_W-1:0] limit_q, limit_d;
    logic [AW-1:0]   post_q, post_d;
    logic [AW-1:0]   remain_q, remain_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   tpos_q, tpos_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [TS_W-1:0] rd_ts_q, rd_ts_d;

    logic [TS_W+DW-1:0] mem [DEPTH];

    logic          we;
    logic          trig_hit;
    logic          load_done;
    logic [AW:0]   fill_inc;
    logic [AW-1:0] oldest;
    logic [AW-1:0] raddr;

    always_comb begin
        case (mode_q)
            2'b00:   trig_hit = bus.trig_i;
            2'b01:   trig_hit = (bus.sample_i[CH_W-1:0] == match_q);
            2'b10:   trig_hit = (stamp_q == limit_q);
            default: trig_hit = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        fill_d    = fill_q;
        stamp_d   = stamp_q;
        mode_d    = mode_q;
        match_d   = match_q;
        limit_d   = limit_q;
        post_d    = post_q;
        remain_d  = remain_q;
        count_d   = count_q;
        tpos_d    = tpos_q;
        rd_data_d = rd_data_q;
        rd_ts_d   = rd_ts_q;
        we        = 1'b0;
        load_done = 1'b0;
        fill_inc  = (fill_q == FillMax) ? fill_q : fill_q + (AW+1)'(1);
        // Frozen window: oldest entry sits count entries behind the write pointer
        oldest    = wptr_q - count_q[AW-1:0];
        raddr     = oldest + bus.rd_addr_i;

        case (state_q)
            StIdle, StDone: begin
                if (bus.arm_i) begin
                    state_d = StPre;
                    wptr_d  = '0;
                    fill_d  = '0;
                    stamp_d = '0;
                    count_d = '0;
                    tpos_d  = '0;
                    mode_d  = bus.mode_i;
                    match_d = bus.match_i;
                    limit_d = bus.limit_i;
                    post_d  = bus.post_i;
                end
            end
            StPre: begin
                stamp_d = stamp_q + TS_W'(1);
                if (bus.sample_v_i) begin
                    we     = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    fill_d = fill_inc;
                    if (trig_hit) begin
                        if (post_q == '0) begin
                            load_done = 1'b1;
                        end else begin
                            state_d  = StPost;
                            remain_d = post_q;
                        end
                    end
                end
            end
            default: begin
                stamp_d = stamp_q + TS_W'(1);
                if (bus.sample_v_i) begin
                    we       = 1'b1;
                    wptr_d   = wptr_q + AW'(1);
                    fill_d   = fill_inc;
                    remain_d = remain_q - AW'(1);
                    load_done = (remain_q == AW'(1));
                end
            end
        endcase

        if (load_done) begin
            state_d = StDone;
            count_d = fill_inc;
            tpos_d  = fill_inc[AW-1:0] - post_q - AW'(1);
        end

        if (state_q == StDone) begin
            {rd_ts_d, rd_data_d} = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wptr_q    <= '0;
            fill_q    <= '0;
            stamp_q   <= '0;
            mode_q    <= '0;
            match_q   <= '0;
            limit_q   <= '0;
            post_q    <= '0;
            remain_q  <= '0;
            count_q   <= '0;
            tpos_q    <= '0;
            rd_data_q <= '0;
            rd_ts_q   <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            fill_q    <= fill_d;
            stamp_q   <= stamp_d;
            mode_q    <= mode_d;
            match_q   <= match_d;
            limit_q   <= limit_d;
            post_q    <= post_d;
            remain_q  <= remain_d;
            count_q   <= count_d;
            tpos_q    <= tpos_d;
            rd_data_q <= rd_data_d;
            rd_ts_q   <= rd_ts_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr_q] <= {stamp_q, bus.sample_i};
        end
    end

    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_ts_o    = rd_ts_q;
    assign bus.state_o    = state_q;
    assign bus.count_o    = count_q;
    assign bus.trig_pos_o = tpos_q;
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: the driver queues expected status and readback,
// a negedge monitor pops and compares whenever a status or read response is due.
module tb_trace_capture;
    localparam int CH_W = 16;
    localparam int NCH  = 4;
    localparam int AW   = 5;
    localparam int TS_W = 16;
    localparam int DW   = NCH * CH_W;

    typedef struct {
        string           name;
        logic [TS_W-1:0] ts;
        logic [DW-1:0]   data;
    } rd_exp_t;

    typedef struct {
        string           name;
        logic [1:0]      st;
        logic [AW:0]     cnt;
        logic [AW-1:0]   tpos;
        bit              chk_ts;
        logic [TS_W-1:0] ts;
    } st_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;
    logic st_req = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rd_exp_t rd_q[$];
    st_exp_t st_q[$];
    rd_exp_t re;
    st_exp_t se;

    trace_capture_if bus ();

    trace_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: read data is due one clock after the request
    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: got ts %0h, expected no response", bus.rd_ts_o);
            end else begin
                re = rd_q.pop_front();
                cmp({re.name, ".ts"}, 64'(bus.rd_ts_o), 64'(re.ts));
                cmp({re.name, ".data"}, 64'(bus.rd_data_o), 64'(re.data));
            end
        end
        if (st_req) begin
            if (st_q.size() == 0) begin
                failures++;
                $display("FAIL st_unexpected: got state %0d, expected no request", bus.state_o);
            end else begin
                se = st_q.pop_front();
                cmp({se.name, ".state"}, 64'(bus.state_o), 64'(se.st));
                cmp({se.name, ".count"}, 64'(bus.count_o), 64'(se.cnt));
                cmp({se.name, ".trig_pos"}, 64'(bus.trig_pos_o), 64'(se.tpos));
                if (se.chk_ts) cmp({se.name, ".rd_ts"}, 64'(bus.rd_ts_o), 64'(se.ts));
            end
        end
    end

    function automatic logic [DW-1:0] pack(input int i);
        logic [DW-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*CH_W +: CH_W] = CH_W'(i + k * 4096);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] m, input int post, input logic [CH_W-1:0] mt,
                       input logic [TS_W-1:0] lim);
        bus.mode_i  = m;
        bus.post_i  = AW'(post);
        bus.match_i = mt;
        bus.limit_i = lim;
        bus.arm_i   = 1'b1;
        step();
        bus.arm_i   = 1'b0;
    endtask

    task automatic store(input logic [DW-1:0] d, input bit t);
        bus.sample_v_i = 1'b1;
        bus.sample_i   = d;
        bus.trig_i     = t;
        step();
        bus.sample_v_i = 1'b0;
        bus.trig_i     = 1'b0;
    endtask

    task automatic exp_status(input string nm, input logic [1:0] st, input int cnt,
                              input int tpos, input bit chk_ts, input int ts);
        st_exp_t e;
        e.name = nm; e.st = st; e.cnt = (AW+1)'(cnt); e.tpos = AW'(tpos);
        e.chk_ts = chk_ts; e.ts = TS_W'(ts);
        st_q.push_back(e);
        st_req = 1'b1;
        @(negedge clk);
        #1;
        st_req = 1'b0;
    endtask

    task automatic exp_read(input string nm, input int addr, input int ts,
                            input logic [DW-1:0] d);
        rd_exp_t e;
        e.name = nm; e.ts = TS_W'(ts); e.data = d;
        rd_q.push_back(e);
        bus.rd_addr_i = AW'(addr);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        bus.arm_i = 1'b0; bus.mode_i = '0; bus.trig_i = 1'b0; bus.match_i = '0;
        bus.limit_i = '0; bus.post_i = '0; bus.sample_v_i = 1'b0; bus.sample_i = '0;
        bus.rd_addr_i = '0;
        step();
        exp_status("reset", 2'b00, 0, 0, 1'b1, 0);
        step();
        rst = 1'b0;
        step();

        // Immediate trigger, 3 post samples
        arm(2'b11, 3, '0, '0);
        for (int i = 0; i < 4; i++) store(pack(i), 1'b0);
        exp_status("m11", 2'b11, 4, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) exp_read($sformatf("m11_rd%0d", i), i, i, pack(i));

        // External trigger after buffer wrap
        arm(2'b00, 4, '0, '0);
        for (int i = 0; i < 40; i++) store(pack(i), (i == 35));
        exp_status("m00", 2'b11, 32, 27, 1'b0, 0);
        exp_read("m00_rd0", 0, 8, pack(8));
        exp_read("m00_rd27", 27, 35, pack(35));
        exp_read("m00_rd31", 31, 39, pack(39));

        // Channel-0 match, no post samples
        arm(2'b01, 0, 16'hBEEF, '0);
        for (int i = 0; i < 6; i++) begin
            d = pack(i);
            if (i == 5) d[CH_W-1:0] = 16'hBEEF;
            store(d, 1'b0);
        end
        exp_status("m01", 2'b11, 6, 5, 1'b0, 0);
        d = pack(5);
        d[CH_W-1:0] = 16'hBEEF;
        exp_read("m01_rd5", 5, 5, d);
        exp_read("m01_rd0", 0, 0, pack(0));

        // Stamp limit with sparse sampling
        arm(2'b10, 2, '0, 16'd24);
        for (int c = 0; c < 29; c++) begin
            bus.sample_v_i = ((c % 2) == 0);
            bus.sample_i   = pack(c);
            step();
        end
        bus.sample_v_i = 1'b0;
        exp_status("m10", 2'b11, 15, 12, 1'b0, 0);
        exp_read("m10_rd12", 12, 24, pack(24));
        exp_read("m10_rd0", 0, 0, pack(0));
        exp_read("m10_rd14", 14, 28, pack(28));

        // Async reset in POST, read port must clear without a clock edge
        arm(2'b11, 3, '0, '0);
        store(pack(0), 1'b0);
        store(pack(1), 1'b0);
        exp_status("post_hold", 2'b10, 0, 0, 1'b1, 28);
        step();
        #2;
        rst = 1'b1;
        exp_status("rst_async", 2'b00, 0, 0, 1'b1, 0);
        step();
        rst = 1'b0;
        step();

        // arm in POST is ignored
        arm(2'b11, 3, '0, '0);
        store(pack(0), 1'b0);
        bus.post_i = '0;
        bus.arm_i  = 1'b1;
        store(pack(1), 1'b0);
        bus.arm_i  = 1'b0;
        exp_status("arm_in_post", 2'b10, 0, 0, 1'b0, 0);
        store(pack(2), 1'b0);
        store(pack(3), 1'b0);
        exp_status("arm_ign_done", 2'b11, 4, 0, 1'b0, 0);

        // Re-arm from DONE restarts stamp and clears status
        arm(2'b11, 0, '0, '0);
        exp_status("rearm_pre", 2'b01, 0, 0, 1'b0, 0);
        store(pack(7), 1'b0);
        exp_status("rearm_done", 2'b11, 1, 0, 1'b0, 0);
        exp_read("rearm_rd0", 0, 0, pack(7));

        step();
        step();
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            failures++;
            $display("FAIL pending: got %0d unchecked responses, expected 0",
                     rd_q.size() + st_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
